// File: rtl/ram_march_tester_pkg.sv
// ram_march_tester_pkg: shared state encoding and march constants
package ram_march_tester_pkg;
  typedef enum logic [2:0] {IDLE, W0, R0W1, R1, DRAIN, DONE} state_t;
  localparam int DRAIN_CYCLES = 2;
  localparam logic [7:0] DEFAULT_PATTERN = 8'h55;
endpackage

// File: rtl/ram_read_checker.sv
// ram_read_checker: aligns each issued read with its returning word and captures the first mismatch
module ram_read_checker #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] expected,
  input  logic [DATA_W-1:0] data,
  output logic              mismatch,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);
  logic              s_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_exp;
  assign mismatch = s_valid && data != s_exp;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s_valid   <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      s_valid <= rd;
      s_addr  <= addr;
      s_exp   <= expected;
      if (mismatch) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= s_addr;
          fail_data <= data;
        end
      end
    end
  end
endmodule

// File: rtl/ram_march_tester.sv
// ram_march_tester: self-test master running a W0 / R0W1 / R1 march over a single-port RAM
module ram_march_tester
  import ram_march_tester_pkg::*;
#(
  parameter int                 ADDR_W       = 8,
  parameter int                 DATA_W       = 8,
  parameter logic [DATA_W-1:0] PATTERN      = DATA_W'(DEFAULT_PATTERN),
  parameter bit                 STOP_ON_FAIL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_data_out
);
  state_t            state, nstate;
  logic [ADDR_W:0]   cnt, ncnt;
  logic [ADDR_W-1:0] n_addr;
  logic [DATA_W-1:0] n_data;
  logic              n_wr, rd, mismatch, clear;
  assign busy  = state inside {W0, R0W1, R1, DRAIN};
  assign done  = state == DONE;
  assign clear = state == IDLE && start;
  assign rd    = state == R1 || (state == R0W1 && !cnt[0]);
  always_comb begin
    nstate = state;
    ncnt   = cnt + 1'b1;
    case (state)
      IDLE: begin
        ncnt = '0;
        if (start) nstate = W0;
      end
      W0: if (&cnt[ADDR_W-1:0]) begin
        nstate = R0W1;
        ncnt   = '0;
      end
      R0W1: if (&cnt) begin
        nstate = R1;
        ncnt   = '0;
      end
      R1: if (&cnt[ADDR_W-1:0]) begin
        nstate = DRAIN;
        ncnt   = '0;
      end
      DRAIN: if (cnt == (ADDR_W+1)'(DRAIN_CYCLES-1)) nstate = DONE;
      default: begin
        nstate = IDLE;
        ncnt   = '0;
      end
    endcase
    // On abort only the read issued alongside the compare is still in flight, so one drain cycle suffices
    if (STOP_ON_FAIL && mismatch && state inside {W0, R0W1, R1}) begin
      nstate = DRAIN;
      ncnt   = (ADDR_W+1)'(DRAIN_CYCLES-1);
    end
    n_wr   = nstate == W0 || (nstate == R0W1 && ncnt[0]);
    n_addr = nstate == W0 ? ncnt[ADDR_W-1:0] : nstate == R0W1 ? ncnt[ADDR_W:1] :
             nstate == R1 ? ~ncnt[ADDR_W-1:0] : '0;
    n_data = nstate == W0 ? PATTERN : nstate == R0W1 ? ~PATTERN : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ram_address <= '0;
      ram_data_in <= '0;
      ram_wr      <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state       <= nstate;
      cnt         <= ncnt;
      ram_address <= n_addr;
      ram_data_in <= n_data;
      ram_wr      <= n_wr;
      pass        <= clear ? 1'b0 : (state == DRAIN && nstate == DONE) ? ~(fail | mismatch) : pass;
    end
  end
  ram_read_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .rd       (rd),
    .addr     (ram_address),
    .expected (state == R1 ? ~PATTERN : PATTERN),
    .data     (ram_data_out),
    .mismatch (mismatch),
    .fail     (fail),
    .fail_addr(fail_addr),
    .fail_data(fail_data)
  );
endmodule

// File: tb/tb_ram_march_tester.sv
// tb_ram_march_tester: two testers (run-to-end and stop-on-fail) against stuck-at RAM models
module tb_ram_march_tester;
  typedef struct {
    bit         inst;
    logic [7:0] fa, fs1, fs0, ga, gs1, gs0;
    bit         e_pass, e_fail;
    logic [7:0] e_addr, e_data;
    int         e_busy;
  } vec_t;
  typedef struct {
    logic [7:0] addr;
    bit         wr;
    logic [7:0] data;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst;
  logic [1:0] start;
  wire  [1:0] busy, done, pass, fail, ram_wr;
  wire  [7:0] fail_addr [2], fail_data [2], ram_address [2], ram_data_in [2];
  logic [7:0] sa1 [2][256], sa0 [2][256];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [256];
    logic [7:0] dout;
    ram_march_tester #(.STOP_ON_FAIL(g == 1)) dut (
      .clk(clk), .rst(rst), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .pass(pass[g]), .fail(fail[g]), .fail_addr(fail_addr[g]), .fail_data(fail_data[g]),
      .ram_address(ram_address[g]), .ram_data_in(ram_data_in[g]), .ram_wr(ram_wr[g]),
      .ram_data_out(dout)
    );
    always @(posedge clk) begin
      if (ram_wr[g])
        mem[ram_address[g]] <= (ram_data_in[g] | sa1[g][ram_address[g]]) & ~sa0[g][ram_address[g]];
      dout <= (mem[ram_address[g]] | sa1[g][ram_address[g]]) & ~sa0[g][ram_address[g]];
    end
  end

  vec_t vecs [8];
  vec_t exp_q [$];
  op_t  op_q [$];
  int   checks = 0, errors = 0;
  int   busy_cnt [2], done_cnt [2];
  bit   act;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, a, e);
    end
  endtask

  task automatic step();
    vec_t e;
    op_t  o;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (busy[k]) busy_cnt[k]++;
      if (done[k]) begin
        done_cnt[k]++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done on tester %0d, required no done", k);
        end else begin
          e = exp_q.pop_front();
          chk("done_tester", 32'(k), 32'(e.inst));
          chk("pass", 32'(pass[k]), 32'(e.e_pass));
          chk("fail", 32'(fail[k]), 32'(e.e_fail));
          chk("fail_addr", 32'(fail_addr[k]), 32'(e.e_addr));
          chk("fail_data", 32'(fail_data[k]), 32'(e.e_data));
          chk("busy_cycles", busy_cnt[k], e.e_busy);
        end
        busy_cnt[k] = 0;
        op_q.delete();
      end
    end
    if (busy[act] && op_q.size() > 0) begin
      o = op_q.pop_front();
      chk("op_addr", 32'(ram_address[act]), 32'(o.addr));
      chk("op_wr", 32'(ram_wr[act]), 32'(o.wr));
      if (o.wr) chk("op_data", 32'(ram_data_in[act]), 32'(o.data));
    end
  endtask

  task automatic push_ops();
    for (int a = 0; a < 256; a++) op_q.push_back('{8'(a), 1'b1, 8'h55});
    for (int a = 0; a < 256; a++) begin
      op_q.push_back('{8'(a), 1'b0, 8'h00});
      op_q.push_back('{8'(a), 1'b1, 8'hAA});
    end
    for (int a = 255; a >= 0; a--) op_q.push_back('{8'(a), 1'b0, 8'h00});
  endtask

  task automatic set_faults(input vec_t v);
    for (int a = 0; a < 256; a++) begin
      sa1[v.inst][a] = 8'h00;
      sa0[v.inst][a] = 8'h00;
    end
    sa1[v.inst][v.fa] |= v.fs1;
    sa0[v.inst][v.fa] |= v.fs0;
    sa1[v.inst][v.ga] |= v.gs1;
    sa0[v.inst][v.ga] |= v.gs0;
  endtask

  task automatic launch(input vec_t v);
    set_faults(v);
    act = v.inst;
    op_q.delete();
    if (!v.inst) push_ops();
    exp_q.push_back(v);
    start[v.inst] = 1'b1;
    step();
    start[v.inst] = 1'b0;
  endtask

  task automatic finish_run(input bit k, input int d0);
    for (int i = 0; i < 3000 && done_cnt[k] == d0; i++) step();
    if (done_cnt[k] == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done on tester %0d, required one", k);
    end
    repeat (4) step();
    chk("single_done", done_cnt[k] - d0, 1);
  endtask

  initial begin
    int d0, n, wr_after;
    vec_t sv;
    vecs[0] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1026};
    vecs[1] = '{1'b0, 8'h3C, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h3C, 8'hAB, 1026};
    vecs[2] = '{1'b0, 8'h10, 8'h80, 8'h00, 8'hF0, 8'h01, 8'h00, 1'b0, 1'b1, 8'h10, 8'hD5, 1026};
    vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h54, 1026};
    vecs[4] = '{1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'hAB, 1026};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1026};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1026};
    vecs[7] = '{1'b1, 8'h3C, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h3C, 8'hAB, 966};
    for (int k = 0; k < 2; k++) begin
      busy_cnt[k] = 0;
      done_cnt[k] = 0;
      for (int a = 0; a < 256; a++) begin
        sa1[k][a] = 8'h00;
        sa0[k][a] = 8'h00;
      end
    end
    act   = 1'b0;
    start = 2'b00;
    rst   = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 32'(busy[k]), 0);
      chk("rst_done", 32'(done[k]), 0);
      chk("rst_pass", 32'(pass[k]), 0);
      chk("rst_fail", 32'(fail[k]), 0);
      chk("rst_fail_addr", 32'(fail_addr[k]), 0);
      chk("rst_fail_data", 32'(fail_data[k]), 0);
      chk("rst_ram_address", 32'(ram_address[k]), 0);
      chk("rst_ram_data_in", 32'(ram_data_in[k]), 0);
      chk("rst_ram_wr", 32'(ram_wr[k]), 0);
    end

    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt[vecs[i].inst];
      launch(vecs[i]);
      finish_run(vecs[i].inst, d0);
    end

    sv = '{1'b1, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h10, 8'hD5, 291};
    d0 = done_cnt[1];
    launch(sv);
    for (int i = 0; i < 2000 && !(busy_cnt[1] > 256 && ram_address[1] == 8'h10 && !ram_wr[1]); i++) step();
    n = 0;
    wr_after = 0;
    for (int i = 0; i < 50 && done_cnt[1] == d0; i++) begin
      step();
      n++;
      if (n >= 2 && ram_wr[1]) wr_after++;
    end
    chk("stop_done_latency", n, 3);
    chk("stop_wr_after_mismatch", wr_after, 0);
    finish_run(1'b1, d0);

    sv = '{1'b0, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h10, 8'hD5, 1026};
    launch(sv);
    for (int i = 0; i < 2000 && busy_cnt[0] < 300; i++) step();
    chk("fail_before_rst", 32'(fail[0]), 1);
    rst = 1'b1;
    step();
    chk("midrun_rst_ram_wr", 32'(ram_wr[0]), 0);
    chk("midrun_rst_busy", 32'(busy[0]), 0);
    chk("midrun_rst_fail", 32'(fail[0]), 0);
    chk("midrun_rst_fail_addr", 32'(fail_addr[0]), 0);
    rst = 1'b0;
    op_q.delete();
    exp_q.delete();
    busy_cnt[0] = 0;
    step();
    d0 = done_cnt[0];
    launch(vecs[0]);
    finish_run(1'b0, d0);

    d0 = done_cnt[0];
    launch(vecs[0]);
    for (int i = 0; i < 2000 && busy_cnt[0] < 100; i++) step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    finish_run(1'b0, d0);
    chk("no_relaunch_busy", 32'(busy[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
